// File: rtl/instr_queue_ctrl_pkg.sv
// Shared types for the instruction queue controller and its instr_register.
// Holds the FSM state type, queue sizing constants and the pointer increment helper.
package instr_queue_ctrl_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t            opc;
    operand_t           op_a;
    operand_t           op_b;
    logic signed [63:0] rezultat;
  } instruction_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } iqc_state_t;

  localparam int unsigned IQC_NREQ     = 2;
  localparam int unsigned IQC_DEPTH    = 32;
  localparam int unsigned IQC_INIT_CYC = 2;
  localparam int unsigned IQC_CNT_W    = 6;

  // The pointer width equals log2(DEPTH), so the natural wrap gives mod-DEPTH.
  function automatic address_t iqc_next_ptr(input address_t p);
    return p + 5'd1;
  endfunction

endpackage

// File: rtl/instr_queue_ctrl_if.sv
// Bus bundle between the issue logic, the queue controller and instr_register.
// slave = controller view, master = surrounding logic view.
interface instr_queue_ctrl_if;
  import instr_queue_ctrl_pkg::*;

  logic                         flush;
  logic     [IQC_NREQ-1:0]      req_valid;
  opcode_t  [IQC_NREQ-1:0]      req_opc;
  operand_t [IQC_NREQ-1:0]      req_op_a;
  operand_t [IQC_NREQ-1:0]      req_op_b;
  logic     [IQC_NREQ-1:0]      req_ready;
  logic                         pop_valid;
  logic                         pop_ready;
  logic                         rsp_valid;
  instruction_t                 rsp_word;
  logic     [IQC_CNT_W-1:0]     count;
  logic                         reg_reset_n;
  logic                         load_en;
  address_t                     write_pointer;
  address_t                     read_pointer;
  opcode_t                      opcode;
  operand_t                     operand_a;
  operand_t                     operand_b;
  instruction_t                 instruction_word;

  modport slave (
    input  flush, req_valid, req_opc, req_op_a, req_op_b, pop_valid, instruction_word,
    output req_ready, pop_ready, rsp_valid, rsp_word, count, reg_reset_n, load_en,
           write_pointer, read_pointer, opcode, operand_a, operand_b
  );

  modport master (
    output flush, req_valid, req_opc, req_op_a, req_op_b, pop_valid, instruction_word,
    input  req_ready, pop_ready, rsp_valid, rsp_word, count, reg_reset_n, load_en,
           write_pointer, read_pointer, opcode, operand_a, operand_b
  );

endinterface

// File: rtl/iqc_arbiter.sv
// Two-way push arbiter. IQC_RR_ARB_EN selects round-robin; otherwise requester 0
// has fixed priority. The grant is combinational so it can act as the ready.
module iqc_arbiter
  import instr_queue_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en_i,
  input  logic [IQC_NREQ-1:0] req_i,
  output logic [IQC_NREQ-1:0] gnt_o
);

`ifdef IQC_RR_ARB_EN
  // prio_q = 1 means requester 1 currently holds priority; flush never touches it.
  logic prio_q;
  logic prio_d;

  // Grant selection and priority rotation after each grant.
  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = prio_q ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end else begin
      gnt_o = 2'b00;
    end
    if (gnt_o[0]) begin
      prio_d = 1'b1;
    end else if (gnt_o[1]) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  logic unused_clk_rst_s;
  assign unused_clk_rst_s = clk ^ reset_n;

  // Fixed priority: requester 0 always wins.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[0]) begin
        gnt_o = 2'b01;
      end else begin
        gnt_o = {req_i[1], 1'b0};
      end
    end else begin
      gnt_o = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/instr_queue_ctrl.sv
// Arbitrates two push requesters into instr_register, runs it as a circular queue
// and serves one in-order consumer. Optional round-robin arbitration: IQC_RR_ARB_EN.
module instr_queue_ctrl
  import instr_queue_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYC = IQC_INIT_CYC
)
(
  input  logic               clk,
  input  logic               reset_n,
  instr_queue_ctrl_if.slave  bus
);

  localparam logic [1:0] INIT_LAST = 2'(INIT_CYC - 1);

  iqc_state_t             state_q,       state_d;
  logic [1:0]             init_cnt_q,    init_cnt_d;
  logic                   reg_reset_n_q, reg_reset_n_d;
  address_t               head_q,        head_d;
  address_t               tail_q,        tail_d;
  logic [IQC_CNT_W-1:0]   count_q,       count_d;
  logic                   load_en_q,     load_en_d;
  address_t               wp_q,          wp_d;
  opcode_t                opc_q,         opc_d;
  operand_t               op_a_q,        op_a_d;
  operand_t               op_b_q,        op_b_d;
  logic                   rsp_valid_q,   rsp_valid_d;
  instruction_t           rsp_word_q,    rsp_word_d;

  logic [IQC_NREQ-1:0]    gnt_s;
  logic [IQC_CNT_W:0]     occ_s;
  logic                   arb_en_s;
  logic                   push_s;
  logic                   sel_s;
  logic                   pop_ready_s;
  logic                   pop_s;

  // A pending write still occupies a slot, so it counts toward the full check.
  assign occ_s       = {1'b0, count_q} + {6'b000000, load_en_q};
  assign arb_en_s    = (state_q == RUN) && !bus.flush && (occ_s < 7'(IQC_DEPTH));
  assign push_s      = |gnt_s;
  assign sel_s       = gnt_s[1];
  assign pop_ready_s = (state_q == RUN) && (count_q != 6'd0);
  assign pop_s       = bus.pop_valid && pop_ready_s && !bus.flush;

  iqc_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (arb_en_s),
    .req_i   (bus.req_valid),
    .gnt_o   (gnt_s)
  );

  // Next-state logic for the FSM, queue pointers and register-side outputs.
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    reg_reset_n_d = reg_reset_n_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    load_en_d     = 1'b0;
    wp_d          = wp_q;
    opc_d         = opc_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rsp_valid_d   = 1'b0;
    rsp_word_d    = rsp_word_q;
    if (bus.flush) begin
      state_d       = INIT;
      init_cnt_d    = 2'd0;
      reg_reset_n_d = 1'b0;
      head_d        = 5'd0;
      tail_d        = 5'd0;
      count_d       = 6'd0;
      wp_d          = 5'd0;
      opc_d         = ZERO;
      op_a_d        = 32'sd0;
      op_b_d        = 32'sd0;
    end else begin
      case (state_q)
        INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            state_d       = RUN;
            init_cnt_d    = 2'd0;
            reg_reset_n_d = 1'b1;
          end else begin
            init_cnt_d    = init_cnt_q + 2'd1;
            reg_reset_n_d = 1'b0;
          end
        end
        RUN: begin
          reg_reset_n_d = 1'b1;
        end
        default: begin
          state_d       = INIT;
          init_cnt_d    = 2'd0;
          reg_reset_n_d = 1'b0;
        end
      endcase
      if (push_s) begin
        load_en_d = 1'b1;
        wp_d      = tail_q;
        opc_d     = bus.req_opc[sel_s];
        op_a_d    = bus.req_op_a[sel_s];
        op_b_d    = bus.req_op_b[sel_s];
        tail_d    = iqc_next_ptr(tail_q);
      end else begin
        load_en_d = 1'b0;
      end
      if (pop_s) begin
        rsp_valid_d = 1'b1;
        rsp_word_d  = bus.instruction_word;
        head_d      = iqc_next_ptr(head_q);
      end else begin
        rsp_valid_d = 1'b0;
      end
      // The write issued last cycle lands in the register at this edge (commit).
      count_d = count_q + {5'd0, load_en_q} - {5'd0, pop_s};
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= INIT;
      init_cnt_q    <= 2'd0;
      reg_reset_n_q <= 1'b0;
      head_q        <= 5'd0;
      tail_q        <= 5'd0;
      count_q       <= 6'd0;
      load_en_q     <= 1'b0;
      wp_q          <= 5'd0;
      opc_q         <= ZERO;
      op_a_q        <= 32'sd0;
      op_b_q        <= 32'sd0;
      rsp_valid_q   <= 1'b0;
      rsp_word_q    <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      reg_reset_n_q <= reg_reset_n_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      load_en_q     <= load_en_d;
      wp_q          <= wp_d;
      opc_q         <= opc_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_word_q    <= rsp_word_d;
    end
  end

  assign bus.req_ready     = gnt_s;
  assign bus.pop_ready     = pop_ready_s;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_word      = rsp_word_q;
  assign bus.count         = count_q;
  assign bus.reg_reset_n   = reg_reset_n_q;
  assign bus.load_en       = load_en_q;
  assign bus.write_pointer = wp_q;
  assign bus.read_pointer  = head_q;
  assign bus.opcode        = opc_q;
  assign bus.operand_a     = op_a_q;
  assign bus.operand_b     = op_b_q;

endmodule
